// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: parallel-to-serial pattern transmitter.
// Accepts a word, a bit length and a repeat count over valid/ready, then shifts
// bits [len-1:0] out MSB-first, one per clock, repeating the pattern
// in_repeat extra times back-to-back, followed by GAP idle cycles.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   request: pattern fields valid
//   in_ready   block can accept (high only in IDLE, combinational)
//   in_data    pattern word; bit len-1 is sent first
//   in_len     bits per pattern; 0 or >WIDTH means WIDTH
//   in_repeat  extra repetitions; total passes = in_repeat+1
//   x          serial bit (registered, 0 when x_valid=0)
//   x_valid    x carries a pattern bit this cycle (registered)
//   done       one-cycle pulse coincident with the final bit of a frame
module serial_pattern_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  input  logic [CNT_W-1:0] in_repeat,
  output logic             x,
  output logic             x_valid,
  output logic             done
);

  localparam logic [LEN_W-1:0] WidthL  = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] OneL    = LEN_W'(1);
  localparam logic [CNT_W-1:0] OneC    = CNT_W'(1);
  localparam int unsigned      GapW    = (GAP > 1) ? $clog2(GAP) : 1;
  // The last-bit cycle already counts as the first GAP-state cycle.
  localparam logic [GapW-1:0]  GapLoad = GapW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] eff_len;
  logic [WIDTH-1:0] src_word;
  logic [LEN_W-1:0] src_idx;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;

  always_comb begin
    if (in_len == '0 || in_len > WidthL) begin
      eff_len = WidthL;
    end else begin
      eff_len = in_len;
    end
  end

  assign in_ready = (state_q == StIdle);

  // Bit selection via shift keeps the index width independent of WIDTH.
  assign shifted = src_word >> src_idx;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    len_d     = len_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    done_d    = 1'b0;
    src_word  = data_q;
    src_idx   = '0;
    last_bit  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d    = in_data;
          len_d     = eff_len;
          idx_d     = eff_len - OneL;
          rep_d     = in_repeat;
          src_word  = in_data;
          src_idx   = eff_len - OneL;
          x_valid_d = 1'b1;
          last_bit  = (eff_len == OneL) && (in_repeat == '0);
        end
      end
      StShift: begin
        if (idx_q != '0) begin
          idx_d     = idx_q - OneL;
          src_idx   = idx_q - OneL;
          x_valid_d = 1'b1;
          last_bit  = (idx_q == OneL) && (rep_q == '0);
        end else if (rep_q != '0) begin
          rep_d     = rep_q - OneC;
          idx_d     = len_q - OneL;
          src_idx   = len_q - OneL;
          x_valid_d = 1'b1;
          last_bit  = (len_q == OneL) && (rep_q == OneC);
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Frame-end decision is taken on the edge that loads the last bit.
    if (x_valid_d) begin
      x_d    = shifted[0];
      done_d = last_bit;
      if (last_bit) begin
        state_d = (GAP > 0) ? StGap : StIdle;
        gap_d   = GapLoad;
      end else begin
        state_d = StShift;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      data_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign done    = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: two instances (GAP=0 and GAP=1) share stimulus.
// A queue-based model expands each accepted request into its per-cycle output
// sequence (bits, then GAP idle cycles); the block is ready exactly when no
// future cycles of the current frame remain queued.
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [3:0] in_len = '0;
  logic [3:0] in_repeat = '0;

  logic x0, xv0, done0, rdy0;
  logic x1, xv1, done1, rdy1;

  int n_tests = 0;
  int n_fail  = 0;

  // Entry = {x, x_valid, done}
  logic [2:0]  q [2][$];
  logic [2:0]  cur [2];
  logic [63:0] cap [2];
  int          ncap [2];
  int          ndone [2];

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(8), .LEN_W(4), .CNT_W(4), .GAP(0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_len(in_len), .in_repeat(in_repeat),
    .x(x0), .x_valid(xv0), .done(done0)
  );

  serial_pattern_tx #(.WIDTH(8), .LEN_W(4), .CNT_W(4), .GAP(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_len(in_len), .in_repeat(in_repeat),
    .x(x1), .x_valid(xv1), .done(done1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Serial stream of one frame, oldest bit in the highest used position.
  task automatic frame_bits(input logic [7:0] data, input logic [3:0] len,
                            input logic [3:0] rep, output logic [63:0] bits, output int n);
    int l;
    l = (len == 0 || len > 8) ? 8 : int'(len);
    bits = '0;
    n = 0;
    for (int r = 0; r <= int'(rep); r++) begin
      for (int i = l - 1; i >= 0; i--) begin
        bits = {bits[62:0], data[i]};
        n++;
      end
    end
  endtask

  task automatic push_frame(input int d, input logic [7:0] data, input logic [3:0] len,
                            input logic [3:0] rep);
    logic [63:0] bits;
    int n;
    frame_bits(data, len, rep, bits, n);
    for (int k = n - 1; k >= 0; k--) q[d].push_back({bits[k], 1'b1, (k == 0)});
    for (int g = 0; g < d; g++) q[d].push_back(3'b000);  // instance d has GAP=d
  endtask

  function automatic logic [3:0] dut_out(input int d);
    return (d == 0) ? {x0, xv0, done0, rdy0} : {x1, xv1, done1, rdy1};
  endfunction

  task automatic clear_cap();
    for (int d = 0; d < 2; d++) begin
      cap[d] = '0;
      ncap[d] = 0;
      ndone[d] = 0;
    end
  endtask

  // One clock: model accepts on current inputs, advances at the edge, and the
  // DUT outputs are compared against it at the following falling edge.
  task automatic step();
    logic [3:0] a;
    for (int d = 0; d < 2; d++) begin
      if (reset && in_valid && q[d].size() == 0) push_frame(d, in_data, in_len, in_repeat);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!reset) q[d].delete();
      cur[d] = (q[d].size() > 0) ? q[d].pop_front() : 3'b000;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      a = dut_out(d);
      check($sformatf("cycle dut_gap%0d {x,xv,done,rdy}", d), 64'(a),
            64'({cur[d], (q[d].size() == 0)}));
      if (a[2]) begin
        cap[d] = {cap[d][62:0], a[3]};
        ncap[d]++;
      end
      if (a[1]) ndone[d]++;
    end
  endtask

  task automatic send(input logic [7:0] data, input logic [3:0] len, input logic [3:0] rep);
    in_data = data;
    in_len = len;
    in_repeat = rep;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (!(rdy0 && rdy1 && !xv0 && !xv1) && budget < 200) begin
      step();
      budget++;
    end
    check("wait_idle timeout", 64'(budget >= 200), 64'(0));
    step();
  endtask

  function automatic int count_101(input logic [63:0] bits, input int n);
    int c;
    logic [63:0] s;
    c = 0;
    for (int i = 0; i + 2 < n; i++) begin
      s = bits >> i;
      if (s[2:0] == 3'b101) c++;
    end
    return c;
  endfunction

  initial begin
    logic [63:0] mb;
    int mn;

    // Pin the model against hand-computed frames.
    frame_bits(8'h05, 4'd3, 4'd2, mb, mn);
    check("model 05/3/2 bits", mb, 64'b101101101);
    check("model 05/3/2 len", 64'(mn), 64'd9);
    frame_bits(8'hA5, 4'd15, 4'd0, mb, mn);
    check("model A5 clamp bits", mb, 64'hA5);

    #1;
    check("reset outputs dut0", 64'(dut_out(0)), 64'b0001);
    check("reset outputs dut1", 64'(dut_out(1)), 64'b0001);
    step();
    step();
    reset = 1'b1;
    step();

    // Basic frame
    clear_cap();
    send(8'h05, 4'd3, 4'd0);
    wait_idle();
    check("basic bits", cap[1], 64'b101);
    check("basic count", 64'(ncap[1]), 64'd3);
    check("basic done", 64'(ndone[1]), 64'd1);

    // Repeat
    clear_cap();
    send(8'h05, 4'd3, 4'd2);
    wait_idle();
    check("repeat bits", cap[1], 64'b101101101);
    check("repeat done", 64'(ndone[1]), 64'd1);
    check("repeat 101 hits", 64'(count_101(cap[1], ncap[1])), 64'd3);

    // Length clamp
    clear_cap();
    send(8'hA5, 4'd0, 4'd0);
    wait_idle();
    check("clamp len0 bits", cap[1], 64'hA5);
    clear_cap();
    send(8'hA5, 4'd15, 4'd0);
    wait_idle();
    check("clamp len15 bits", cap[1], 64'hA5);
    check("clamp len15 count", 64'(ncap[1]), 64'd8);

    // Back-to-back on the GAP=0 instance
    clear_cap();
    in_data = 8'h03; in_len = 4'd2; in_repeat = 4'd0; in_valid = 1'b1;
    step();
    in_data = 8'h02;
    step();
    step();
    in_valid = 1'b0;
    wait_idle();
    check("b2b bits", cap[0], 64'b1110);
    check("b2b done", 64'(ndone[0]), 64'd2);

    // Busy-ignore
    clear_cap();
    send(8'hA5, 4'd8, 4'd1);
    step();
    step();
    in_data = 8'hFF; in_len = 4'd3; in_valid = 1'b1;
    step();
    check("busy ready dut1", 64'(rdy1), 64'd0);
    in_valid = 1'b0;
    wait_idle();
    check("busy bits", cap[1], 64'hA5A5);
    check("busy count", 64'(ncap[1]), 64'd16);

    // Reset mid-frame, asserted between edges
    clear_cap();
    send(8'h05, 4'd3, 4'd2);
    step();
    #2 reset = 1'b0;
    #1;
    check("async reset dut0", 64'(dut_out(0)), 64'b0001);
    check("async reset dut1", 64'(dut_out(1)), 64'b0001);
    q[0].delete();
    q[1].delete();
    step();
    reset = 1'b1;
    step();
    check("abort done", 64'(ndone[1]), 64'd0);
    clear_cap();
    send(8'h05, 4'd3, 4'd0);
    wait_idle();
    check("post-reset bits", cap[1], 64'b101);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      in_data = 8'($urandom);
      in_len = 4'($urandom_range(0, 15));
      in_repeat = 4'($urandom_range(0, 3));
      step();
    end
    in_valid = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Parallel-to-serial pattern transmitter. Generates the single-bit serial stream that the team's FSM sequence detectors consume.
- Accepts a word, a bit length and a repeat count over a valid/ready handshake. Shifts the word out MSB-first, one bit per clock, with a qualifying strobe.
- Drives detector benches and on-chip self-test of the detector path.

Parameters:
WIDTH, 8, maximum pattern length in bits (data word width)
LEN_W, 4, width of in_len; must satisfy 2**LEN_W > WIDTH
CNT_W, 4, width of in_repeat (extra repetitions of the pattern)
GAP, 1, idle cycles (x=0, x_valid=0) inserted after each frame; 0 allowed

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  request: pattern fields valid
in_ready  output  1  block can accept (high only in IDLE)
in_data  input  WIDTH  pattern; bits [len-1:0] are sent, bit len-1 first
in_len  input  LEN_W  bits per pattern; 0 or >WIDTH means WIDTH
in_repeat  input  CNT_W  extra repetitions; total passes = in_repeat+1
x  output  1  serial bit, registered
x_valid  output  1  x carries a pattern bit this cycle, registered
done  output  1  one-cycle pulse coincident with the final bit of a frame

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; x=0, x_valid=0, done=0; internal registers cleared; in_ready=1.
- Reset mid-frame aborts immediately: no further bits, no done. Deassertion returns to IDLE.
- States: IDLE, SHIFT, GAP.
- in_ready is combinational: 1 iff state==IDLE.
- Accept: rising edge with in_valid=1 and in_ready=1.
  - Latch in_data, effective length L (clamped), and in_repeat into rep_cnt.
  - Set bit index idx=L-1. Same edge: x<=in_data[L-1], x_valid<=1, state<=SHIFT. Latency from accept edge to first bit is 1 edge.
  - Inputs are ignored while not in IDLE; changes to in_data mid-frame have no effect.
- SHIFT, each edge:
  - If idx>0: idx--, x<=data[idx-1], x_valid=1.
  - If idx==0 and rep_cnt>0: rep_cnt--, idx=L-1, x<=data[L-1]. Repetitions are back-to-back with no bubble.
  - If idx==0 and rep_cnt==0, the frame is complete.
- A frame occupies exactly L*(in_repeat+1) consecutive x_valid cycles.
- done=1 during the cycle the last bit is on x. It is registered alongside that bit.
- End of frame, applied on the edge that loads the last bit:
  - GAP>0: next state=GAP.
  - GAP==0: next state=IDLE. in_ready=1 during the last-bit cycle, so a new accept on the following edge produces gapless back-to-back frames.
- GAP state:
  - x=0, x_valid=0, done=0 for exactly GAP cycles, then IDLE.
  - in_ready is therefore first high GAP cycles after the last-bit cycle.
- When x_valid=0, x is forced to 0.
- L=1: single-bit frames are legal. A frame with in_repeat=0 has done coincident with its only bit.
- Counters have no wrap-around: idx is bounded by L-1 and rep_cnt by 2**CNT_W-1. Maximum frame length is WIDTH*2**CNT_W bits.

Test Plan:
- Basic, GAP=1: in_data=8'h05, in_len=3, in_repeat=0 -> x_valid high 3 cycles, x=1,0,1, done on the 3rd. x_valid=0 for 1 cycle, then in_ready=1.
- Repeat: in_data=8'h05, in_len=3, in_repeat=2 -> 9 consecutive bits 101101101, done only on the 9th. Fed to the overlapping 101 sequence detector, this gives exactly 3 detections.
- Length clamp: in_len=0 and in_len=15 with in_data=8'hA5 -> 8 bits 10100101 both times, done on the 8th.
- Back-to-back, GAP=0: in_valid held high, frames 8'h03/len 2 then 8'h02/len 2 -> x_valid continuous 4 cycles, x=1,1,1,0, done on cycles 2 and 4.
- Busy-ignore: change in_data and pulse in_valid mid-frame -> transmitted bits unchanged, in_ready stays 0 until the frame (plus gap) ends.
- Reset mid-frame: assert reset after 2 bits of a 9-bit frame, asynchronously between edges -> x, x_valid, done go 0 immediately, no done. After release, in_ready=1 and a new frame transmits correctly.
